// File: rtl/req_encoder_hs_pkg.sv
// -----------------------------------------------------------------------------
// req_encoder_hs_pkg
// Shared definitions for the request encoder:
//   - clog2()      : ceiling log2, used to size the index from the request count
//   - ARB_FIXED    : arbitration mode, lowest set index wins
//   - ARB_RR       : arbitration mode, round-robin from a rotating pointer
//   - idx_t        : index type for the default four-request configuration
// -----------------------------------------------------------------------------
package req_encoder_hs_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Ceiling log2; returns the number of bits needed to index 'value' items.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = clog2(N_DEFAULT);

    typedef logic [W_DEFAULT-1:0] idx_t;

endpackage : req_encoder_hs_pkg

// File: rtl/req_encoder_hs_prio_pick.sv
// -----------------------------------------------------------------------------
// req_encoder_hs_prio_pick
// Combinational circular priority picker. Scans the candidate vector upward
// starting at 'start', wrapping from N-1 back to 0, and reports the first set
// position. With start tied to zero this is a plain lowest-index encoder.
// Ports:
//   c     [N-1:0]  candidate request vector
//   start [W-1:0]  first position to examine (must be < N)
//   idx   [W-1:0]  selected position (0 when nothing is set)
//   any            at least one candidate bit is set
// -----------------------------------------------------------------------------
module req_encoder_hs_prio_pick
    import req_encoder_hs_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] c,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);

    // Circular first-one search; the first hit along the scan order wins.
    always_comb begin
        int j;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            // Position visited at step k, wrapped into 0..N-1.
            j = (int'(start) + k) % N;
            if (!any && c[j]) begin
                idx = W'(j);
                any = 1'b1;
            end else begin
                idx = idx;
            end
        end
    end

endmodule : req_encoder_hs_prio_pick

// File: rtl/req_encoder_hs.sv
// -----------------------------------------------------------------------------
// req_encoder_hs
// Collapses N request lines into a stream of binary indices. Incoming request
// levels are merged into a sticky pending register, one request is selected
// per load (fixed priority or round-robin) and presented on a registered
// output guarded by a Valid/Ready handshake.
// Ports:
//   Clk              rising-edge clock
//   Rst_n            asynchronous active-low reset
//   In      [N-1:0]  request levels, sampled every cycle
//   Out     [W-1:0]  index of the granted request (stable while Valid && !Ready)
//   Valid            Out carries an index not yet consumed
//   Ready            consumer takes Out on an edge where Valid && Ready
//   Pending [N-1:0]  requests seen but not yet issued (status)
//   Drop             one-cycle pulse: a request hit an already pending index
// -----------------------------------------------------------------------------
module req_encoder_hs
    import req_encoder_hs_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = clog2(N),
    parameter int RR = ARB_FIXED
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic [N-1:0] In,
    output logic [W-1:0] Out,
    output logic         Valid,
    input  logic         Ready,
    output logic [N-1:0] Pending,
    output logic         Drop
);

    logic [W-1:0] out_q,     out_d;
    logic         valid_q,   valid_d;
    logic [N-1:0] pending_q, pending_d;
    logic         drop_q,    drop_d;
    logic [W-1:0] ptr_q,     ptr_d;

    logic [N-1:0] cand_s;
    logic         load_s;
    logic [W-1:0] start_s;
    logic [W-1:0] pick_idx_s;
    logic         pick_any_s;
    logic [N-1:0] grant_mask_s;

    // Candidates are everything still pending plus whatever arrives this cycle.
    assign cand_s = pending_q | In;

    // The output slot can take a new index when empty or being drained now.
    assign load_s = !valid_q || Ready;

    // Fixed priority always scans from index 0; round-robin scans from ptr.
    assign start_s = (RR == ARB_RR) ? ptr_q : '0;

    req_encoder_hs_prio_pick #(
        .N (N),
        .W (W)
    ) u_prio_pick (
        .c     (cand_s),
        .start (start_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // One-hot of the index actually granted at this edge (zero if no grant).
    always_comb begin
        if (load_s && pick_any_s) begin
            grant_mask_s = N'(1) << pick_idx_s;
        end else begin
            grant_mask_s = '0;
        end
    end

    // Next-state for the output slot, pending register and rotation pointer.
    always_comb begin
        out_d     = out_q;
        valid_d   = valid_q;
        pending_d = cand_s;
        ptr_d     = ptr_q;
        if (load_s) begin
            if (pick_any_s) begin
                out_d     = pick_idx_s;
                valid_d   = 1'b1;
                // A fresh level on the granted bit is absorbed by this grant.
                pending_d = cand_s & ~grant_mask_s;
                ptr_d     = (pick_idx_s == W'(N - 1)) ? '0 : (pick_idx_s + W'(1));
            end else begin
                // Out keeps its last value; it is meaningless while Valid=0.
                valid_d   = 1'b0;
                pending_d = '0;
            end
        end else begin
            // Slot occupied and not consumed: just accumulate requests.
            out_d     = out_q;
            valid_d   = valid_q;
            pending_d = cand_s;
        end
    end

    // Drop flags a request landing on a pending bit that is not granted now.
    // An index sitting in Out is no longer pending, so re-requesting it is a
    // new request rather than a drop.
    always_comb begin
        if (|(In & pending_q & ~grant_mask_s)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = 1'b0;
        end
    end

    // State registers; reset discards every pending and in-flight index.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_q     <= '0;
            valid_q   <= 1'b0;
            pending_q <= '0;
            drop_q    <= 1'b0;
            ptr_q     <= '0;
        end else begin
            out_q     <= out_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            ptr_q     <= ptr_d;
        end
    end

    assign Out     = out_q;
    assign Valid   = valid_q;
    assign Pending = pending_q;
    assign Drop    = drop_q;

endmodule : req_encoder_hs

// File: tb/tb_req_encoder_hs.sv
// -----------------------------------------------------------------------------
// tb_req_encoder_hs
// Directed bench for req_encoder_hs: a fixed-priority instance and a
// round-robin instance share clock and reset. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_req_encoder_hs;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_fx;
    logic       ready_fx;
    logic [1:0] out_fx;
    logic       valid_fx;
    logic [3:0] pending_fx;
    logic       drop_fx;
    logic [3:0] in_rr;
    logic       ready_rr;
    logic [1:0] out_rr;
    logic       valid_rr;
    logic [3:0] pending_rr;
    logic       drop_rr;

    int checks;
    int errors;

    req_encoder_hs #(.N(4), .W(2), .RR(0)) dut_fx (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .In      (in_fx),
        .Out     (out_fx),
        .Valid   (valid_fx),
        .Ready   (ready_fx),
        .Pending (pending_fx),
        .Drop    (drop_fx)
    );

    req_encoder_hs #(.N(4), .W(2), .RR(1)) dut_rr (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .In      (in_rr),
        .Out     (out_rr),
        .Valid   (valid_rr),
        .Ready   (ready_rr),
        .Pending (pending_rr),
        .Drop    (drop_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_fx = 4'b1111; ready_fx = 1'b0;
        step(); step();
        checks++; if (valid_fx !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_fx); end
        checks++; if (pending_fx !== 4'b0000) begin errors++; $display("FAIL reset_pending got=%b exp=0000", pending_fx); end
        checks++; if (drop_fx !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop_fx); end
        checks++; if (out_fx !== 2'd0) begin errors++; $display("FAIL reset_out got=%0d exp=0", out_fx); end
        rst_n = 1'b1;
        step();
        checks++; if (out_fx !== 2'd0) begin errors++; $display("FAIL rel_out got=%0d exp=0", out_fx); end
        checks++; if (valid_fx !== 1'b1) begin errors++; $display("FAIL rel_valid got=%b exp=1", valid_fx); end
        checks++; if (pending_fx !== 4'b1110) begin errors++; $display("FAIL rel_pending got=%b exp=1110", pending_fx); end
        in_fx = 4'b0000; ready_fx = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (out_fx !== 2'(i) || valid_fx !== 1'b1) begin errors++; $display("FAIL rel_drain got=%0d/%b exp=%0d/1", out_fx, valid_fx, i); end
        end
        step();
        checks++; if (valid_fx !== 1'b0 || pending_fx !== 4'b0000) begin errors++; $display("FAIL rel_empty got=%b/%b exp=0/0000", valid_fx, pending_fx); end
    endtask

    task automatic test_fixed_priority();
        ready_fx = 1'b1; in_fx = 4'b1010;
        step();
        in_fx = 4'b0000;
        checks++; if (out_fx !== 2'd1 || valid_fx !== 1'b1 || pending_fx !== 4'b1000) begin errors++; $display("FAIL fx_first got=%0d/%b/%b exp=1/1/1000", out_fx, valid_fx, pending_fx); end
        step();
        checks++; if (out_fx !== 2'd3 || valid_fx !== 1'b1 || pending_fx !== 4'b0000) begin errors++; $display("FAIL fx_second got=%0d/%b/%b exp=3/1/0000", out_fx, valid_fx, pending_fx); end
        step();
        checks++; if (valid_fx !== 1'b0 || pending_fx !== 4'b0000) begin errors++; $display("FAIL fx_idle got=%b/%b exp=0/0000", valid_fx, pending_fx); end
    endtask

    task automatic test_backpressure();
        ready_fx = 1'b0; in_fx = 4'b0100;
        step();
        in_fx = 4'b0000;
        checks++; if (out_fx !== 2'd2 || valid_fx !== 1'b1) begin errors++; $display("FAIL bp_load got=%0d/%b exp=2/1", out_fx, valid_fx); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (out_fx !== 2'd2 || valid_fx !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got=%0d/%b exp=2/1", i, out_fx, valid_fx); end
        end
        ready_fx = 1'b1;
        step();
        checks++; if (valid_fx !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", valid_fx); end
    endtask

    task automatic test_drop();
        ready_fx = 1'b0; in_fx = 4'b0001;
        step();
        checks++; if (out_fx !== 2'd0 || valid_fx !== 1'b1 || drop_fx !== 1'b0) begin errors++; $display("FAIL dr_load got=%0d/%b/%b exp=0/1/0", out_fx, valid_fx, drop_fx); end
        in_fx = 4'b1000;
        step();
        checks++; if (pending_fx !== 4'b1000 || drop_fx !== 1'b0) begin errors++; $display("FAIL dr_first got=%b/%b exp=1000/0", pending_fx, drop_fx); end
        in_fx = 4'b0000;
        step();
        checks++; if (drop_fx !== 1'b0) begin errors++; $display("FAIL dr_gap got=%b exp=0", drop_fx); end
        in_fx = 4'b1000;
        step();
        checks++; if (drop_fx !== 1'b1 || pending_fx !== 4'b1000) begin errors++; $display("FAIL dr_second got=%b/%b exp=1/1000", drop_fx, pending_fx); end
        in_fx = 4'b0000;
        step();
        checks++; if (drop_fx !== 1'b0 || out_fx !== 2'd0) begin errors++; $display("FAIL dr_pulse got=%b/%0d exp=0/0", drop_fx, out_fx); end
        ready_fx = 1'b1;
        step();
        checks++; if (out_fx !== 2'd3 || valid_fx !== 1'b1 || pending_fx !== 4'b0000) begin errors++; $display("FAIL dr_stream got=%0d/%b/%b exp=3/1/0000", out_fx, valid_fx, pending_fx); end
        step();
        checks++; if (valid_fx !== 1'b0) begin errors++; $display("FAIL dr_end got=%b exp=0", valid_fx); end
    endtask

    task automatic test_rerequest();
        // Re-request of the index currently in Out: new request, no drop.
        ready_fx = 1'b0; in_fx = 4'b0010;
        step();
        step();
        checks++; if (pending_fx !== 4'b0010 || drop_fx !== 1'b0 || out_fx !== 2'd1) begin errors++; $display("FAIL rq_pend got=%b/%b/%0d exp=0010/0/1", pending_fx, drop_fx, out_fx); end
        in_fx = 4'b0000; ready_fx = 1'b1;
        step();
        checks++; if (out_fx !== 2'd1 || valid_fx !== 1'b1 || pending_fx !== 4'b0000) begin errors++; $display("FAIL rq_reissue got=%0d/%b/%b exp=1/1/0000", out_fx, valid_fx, pending_fx); end
        step();
        // Request on a pending bit in the very cycle it is granted: merged.
        ready_fx = 1'b0; in_fx = 4'b0001;
        step();
        in_fx = 4'b0100;
        step();
        ready_fx = 1'b1;
        step();
        checks++; if (out_fx !== 2'd2 || drop_fx !== 1'b0 || pending_fx !== 4'b0000) begin errors++; $display("FAIL rq_merge got=%0d/%b/%b exp=2/0/0000", out_fx, drop_fx, pending_fx); end
        in_fx = 4'b0000;
        step();
        checks++; if (valid_fx !== 1'b0) begin errors++; $display("FAIL rq_end got=%b exp=0", valid_fx); end
    endtask

    task automatic test_round_robin();
        ready_rr = 1'b1; in_rr = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (out_rr !== 2'(i % 4) || valid_rr !== 1'b1 || drop_rr !== (i > 0)) begin errors++; $display("FAIL rr_seq cyc=%0d got=%0d/%b/%b exp=%0d/1/%b", i, out_rr, valid_rr, drop_rr, i % 4, (i > 0)); end
        end
        in_rr = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_rr !== 2'(i) || valid_rr !== 1'b1) begin errors++; $display("FAIL rr_drain cyc=%0d got=%0d/%b exp=%0d/1", i, out_rr, valid_rr, i); end
        end
        step();
        checks++; if (valid_rr !== 1'b0 || pending_rr !== 4'b0000) begin errors++; $display("FAIL rr_empty got=%b/%b exp=0/0000", valid_rr, pending_rr); end
    endtask

    task automatic test_mid_reset();
        ready_fx = 1'b0; in_fx = 4'b0111;
        step();
        in_fx = 4'b0000;
        checks++; if (pending_fx !== 4'b0110 || valid_fx !== 1'b1) begin errors++; $display("FAIL mr_setup got=%b/%b exp=0110/1", pending_fx, valid_fx); end
        rst_n = 1'b0;
        #2;
        checks++; if (valid_fx !== 1'b0 || pending_fx !== 4'b0000 || out_fx !== 2'd0) begin errors++; $display("FAIL mr_async got=%b/%b/%0d exp=0/0000/0", valid_fx, pending_fx, out_fx); end
        #3;
        rst_n = 1'b1;
        ready_fx = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (valid_fx !== 1'b0 || pending_fx !== 4'b0000) begin errors++; $display("FAIL mr_stale cyc=%0d got=%b/%b exp=0/0000", i, valid_fx, pending_fx); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; in_fx = 4'b0000; ready_fx = 1'b0;
        in_rr = 4'b0000; ready_rr = 1'b1;
        test_reset();
        test_fixed_priority();
        test_backpressure();
        test_drop();
        test_rerequest();
        test_round_robin();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_req_encoder_hs

// File: doc/req_encoder_hs.md
Name: req_encoder_hs

Overview:
- Counterpart of the team's 2-to-4 one-hot decoder: it converts a set of N request lines back into a binary index.
- Requests are latched into a sticky pending register and priority-encoded.
- The resulting index is presented on a registered output with a Valid/Ready handshake.
- Typical use: collapsing per-channel event strobes into one index stream for a downstream consumer.

Parameters:
- N, 4, number of request inputs (≥2).
- W, 2, index width, equal to clog2(N).
- RR, 0, arbitration mode: 0 = fixed priority (In[0] highest), 1 = round-robin.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  asynchronous reset, active-low.
- In  input  N  request lines; a level sampled each cycle, and any 1 means a request on that index.
- Out  output  W  encoded index of the granted request.
- Valid  output  1  Out holds an index not yet consumed.
- Ready  input  1  consumer accepts Out when Valid && Ready at a rising edge.
- Pending  output  N  pending-request register (status only).
- Drop  output  1  one-cycle pulse: a request arrived on an index that was already pending.

Behaviour:
- Reset, asserted asynchronously while Rst_n=0: Out=0, Valid=0, Pending=0, Drop=0, round-robin pointer=0. Deassertion takes effect at the next Clk edge.
- Reset mid-operation discards all pending and in-flight indices; nothing is replayed.
- Candidate vector: C = Pending | In, all evaluated combinationally each cycle.
- Load condition: load = !Valid || Ready. The output slot is empty, or it is being consumed this edge.
- On a rising edge with load=1 and C≠0:
  - Out ← selected index, Valid ← 1.
  - Pending ← (C with the selected bit cleared).
- On a rising edge with load=1 and C=0: Valid ← 0, Pending ← 0. Out holds its last value (don't-care).
- On a rising edge with load=0: Out and Valid hold; Pending ← C.
- Out must stay stable while Valid && !Ready.
- Latency: In asserted before edge t with an empty slot gives Valid=1 and the correct Out after edge t (1 cycle).
- Back-to-back operation: with Ready held at 1, one index is issued per cycle.
- Selection, RR=0: lowest set index in C.
- Selection, RR=1: first set index in C scanning upward from pointer ptr, wrapping from N-1 to 0.
  - ptr ← (granted index + 1) mod N on each load with C≠0.
  - ptr holds otherwise.
- Same index requested again while its previous grant sits in Out is a new request. It is set in Pending, is not a drop, and is issued again later.
- Request on a bit already in Pending in the same cycle it is granted: the grant consumes it, the new level is merged into that one grant, and Drop is not pulsed.
- Drop rule: Drop ← 1 at the edge where In[i]=1, Pending[i]=1, and i is not the index granted at that edge; otherwise Drop ← 0.
  - Multiple simultaneous drops produce a single pulse.
  - A level held on In for k cycles while pending produces Drop on each of those cycles. Upstream is expected to pulse.
- Width: Out is zero-extended; indices ≥ N never appear.

Decomposition:
- Shared package holds:
  - clog2 function.
  - Localparams ARB_FIXED=0 and ARB_RR=1.
  - Typedef for the index type, logic [W-1:0].
- One sub-module is natural: prio_pick.
  - Combinational; inputs C[N-1:0] and start[W-1:0]; outputs idx[W-1:0] and any.
  - Fixed mode ties start=0.
  - Keeps the masking/wrap logic out of the handshake and state code.

Test Plan:
- Reset: hold Rst_n=0, drive In=4'b1111 → Valid=0, Pending=0, Drop=0 during reset. After release, first edge gives Out=0, Valid=1, Pending=4'b1110.
- Fixed priority, Ready=1: pulse In=4'b1010 for one cycle → Out sequence 1, 3 on consecutive cycles, then Valid=0 and Pending=0.
- Backpressure, Ready=0: pulse In=4'b0100 → Out=2 and Valid=1 held stable for 5 cycles. Raise Ready → Valid drops after one edge.
- Drop: Ready=0 with Out=0 held, pulse In[3] twice (two separate cycles) → Pending[3]=1 and one Drop pulse on the second request. Final stream after Ready=1 is 0, 3.
- Round-robin (RR=1), Ready=1: hold In=4'b1111 for 8 cycles → Out=0,1,2,3,0,1,2,3, with Drop asserted each cycle after the first.
- Reset mid-operation: Pending=4'b0110 and Valid=1; pulse Rst_n low for half a cycle → immediate Valid=0, Pending=0. No stale index appears after release.
